// File: rtl/vga_vblank_scheduler.sv
// Shares the vertical blanking interval among N_REQ requesters. Grants are
// round-robin, one at a time, at most once per frame, and revoked when active video resumes.
module vga_vblank_scheduler #(
    parameter int N_REQ        = 4,
    parameter int ACTIVE_LINES = 480,
    parameter int MAX_GRANT    = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [9:0]       y,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_id,
    output logic             window,
    output logic             frame_tick,
    output logic             overrun
);

    localparam int TW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_GRANT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             in_blank_reg, in_blank_next;
    logic [N_REQ-1:0] served_reg, served_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [2:0]       rr_ptr_reg, rr_ptr_next;
    logic [2:0]       grant_id_reg, grant_id_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic             window_reg, window_next;
    logic             frame_tick_reg, frame_tick_next;
    logic             overrun_reg, overrun_next;

    logic             in_blank, blank_rise, blank_fall;
    logic [7:0]       eligible_pad, done_pad, onehot_pad;
    logic [2:0]       cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic             found;
    logic [2:0]       sel_idx;
    logic             grant_done, timeout;
    logic [3:0]       id_inc;
    logic [2:0]       rr_after;

    assign in_blank   = (int'(y) >= ACTIVE_LINES);
    assign blank_rise = in_blank & ~in_blank_reg;
    assign blank_fall = ~in_blank & in_blank_reg;

    assign eligible_pad = 8'(req & ~served_reg);
    assign done_pad     = 8'(done);
    assign grant_done   = done_pad[grant_id_reg];
    assign timeout      = (timer_reg == TIMER_LAST);

    assign id_inc   = {1'b0, grant_id_reg} + 4'd1;
    assign rr_after = (id_inc >= 4'(N_REQ)) ? 3'd0 : id_inc[2:0];

    // Candidate gi is the requester gi places after rr_ptr, wrapping modulo N_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + 4'(gi);
            assign cand_idx[gi] = (sum >= 4'(N_REQ)) ? (sum[2:0] - 3'(N_REQ)) : sum[2:0];
            assign cand_hit[gi] = eligible_pad[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                found   = 1'b1;
                sel_idx = cand_idx[k];
            end
        end
    end

    assign onehot_pad = 8'd1 << sel_idx;

    always_comb begin
        state_next      = state_reg;
        in_blank_next   = in_blank_reg;
        served_next     = served_reg;
        rr_ptr_next     = rr_ptr_reg;
        grant_next      = grant_reg;
        grant_id_next   = grant_id_reg;
        timer_next      = timer_reg;
        window_next     = window_reg;
        frame_tick_next = 1'b0;
        overrun_next    = 1'b0;
        if (enable) begin
            in_blank_next = in_blank;
            if (blank_fall) begin
                // Video resumes: close wins over any done in the same cycle.
                state_next  = IDLE;
                window_next = 1'b0;
                grant_next  = '0;
                timer_next  = '0;
                if (state_reg == GRANT) begin
                    overrun_next = 1'b1;
                    served_next  = served_reg | grant_reg;
                    rr_ptr_next  = rr_after;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (blank_rise) begin
                            state_next      = ARB;
                            window_next     = 1'b1;
                            frame_tick_next = 1'b1;
                            served_next     = '0;
                        end
                    end
                    ARB: begin
                        if (found) begin
                            state_next    = GRANT;
                            grant_next    = onehot_pad[N_REQ-1:0];
                            grant_id_next = sel_idx;
                            timer_next    = '0;
                        end
                    end
                    GRANT: begin
                        if (grant_done || timeout) begin
                            state_next   = ARB;
                            grant_next   = '0;
                            served_next  = served_reg | grant_reg;
                            rr_ptr_next  = rr_after;
                            overrun_next = ~grant_done;
                            timer_next   = '0;
                        end else begin
                            timer_next = timer_reg + TW'(1);
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // in_blank_reg resets high so a window already open at reset release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            in_blank_reg   <= 1'b1;
            served_reg     <= '0;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            grant_id_reg   <= '0;
            timer_reg      <= '0;
            window_reg     <= 1'b0;
            frame_tick_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            in_blank_reg   <= in_blank_next;
            served_reg     <= served_next;
            rr_ptr_reg     <= rr_ptr_next;
            grant_reg      <= grant_next;
            grant_id_reg   <= grant_id_next;
            timer_reg      <= timer_next;
            window_reg     <= window_next;
            frame_tick_reg <= frame_tick_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign grant      = grant_reg;
    assign grant_id   = grant_id_reg;
    assign window     = window_reg;
    assign frame_tick = frame_tick_reg;
    assign overrun    = overrun_reg;

endmodule
